// File: rtl/tournament_max_finder_if.sv
// -----------------------------------------------------------------------------
// tournament_max_finder_if
//   Handshake bundle for tournament_max_finder.
//   Input side : in_valid / in_ready with the N_IN-sample vector in_data.
//   Output side: out_valid / out_ready with out_value, out_index and the
//                round-1 pairwise compare vector round1_cmp; busy flags a
//                reduction in progress.
//   slave  modport : the reduction block.
//   master modport : the producer/consumer around it.
// -----------------------------------------------------------------------------
interface tournament_max_finder_if #(
  parameter int N_IN   = 16,
  parameter int DATA_W = 13
);
  localparam int LOG2N = $clog2(N_IN);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data [0:N_IN-1];
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_value;
  logic [LOG2N-1:0]    out_index;
  logic [N_IN/2-1:0]   round1_cmp;
  logic                busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_value, out_index, round1_cmp, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_value, out_index, round1_cmp, busy
  );
endinterface

// File: rtl/tournament_max_finder.sv
// -----------------------------------------------------------------------------
// tournament_max_finder
//   Iterative tournament reduction over N_IN unsigned DATA_W-bit samples.
//   One layer of N_IN/2 pairwise comparators is reused for LOG2N rounds; the
//   winning value and its original input index are presented with a
//   valid/ready handshake. The round-1 compare outcomes are exported as
//   round1_cmp (bit i set when sample 2i+1 beat sample 2i).
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous reset, active low (aborts any reduction)
//     bus    : tournament_max_finder_if.slave
//              in_valid/in_ready/in_data, out_valid/out_ready,
//              out_value/out_index/round1_cmp, busy
//
//   Configuration
//     TMF_MIN_MODE_EN : when defined the tournament selects the minimum
//                       instead of the maximum. Ties go to the even slot in
//                       both modes, so the lowest index wins on equal values.
// -----------------------------------------------------------------------------
module tournament_max_finder #(
  parameter int N_IN   = 16,
  parameter int DATA_W = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tournament_max_finder_if.slave bus
);
  localparam int LOG2N = $clog2(N_IN);
  localparam int NPAIR = N_IN / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LOG2N-1:0]    rnd_q, rnd_d;
  logic [DATA_W-1:0]   val_q [0:N_IN-1];
  logic [DATA_W-1:0]   val_d [0:N_IN-1];
  logic [LOG2N-1:0]    idx_q [0:N_IN-1];
  logic [LOG2N-1:0]    idx_d [0:N_IN-1];
  logic [NPAIR-1:0]    r1_q, r1_d;
  logic [DATA_W-1:0]   out_value_q, out_value_d;
  logic [LOG2N-1:0]    out_index_q, out_index_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  // The odd slot only takes over on a strict win, which keeps the lower
  // index on ties.
  function automatic logic b_wins(input logic [DATA_W-1:0] a,
                                  input logic [DATA_W-1:0] b);
`ifdef TMF_MIN_MODE_EN
    return b < a;
`else
    return b > a;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    val_d       = val_q;
    idx_d       = idx_q;
    r1_d        = r1_q;
    out_value_d = out_value_q;
    out_index_d = out_index_q;

    case (state_q)
      IDLE: begin
        // in_ready_q is still low on the first cycle after reset release.
        if (bus.in_valid && in_ready_q) begin
          for (int j = 0; j < N_IN; j++) begin
            val_d[j] = bus.in_data[j];
            idx_d[j] = LOG2N'(j);
          end
          rnd_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Round r reduces the N_IN>>r live slots to N_IN>>(r+1); all reads
        // come from the _q copy, so writing slot i never disturbs the pair
        // 2i/2i+1 that feeds it.
        for (int i = 0; i < NPAIR; i++) begin
          if (i < (NPAIR >> rnd_q)) begin
            if (b_wins(val_q[2*i], val_q[2*i+1])) begin
              val_d[i] = val_q[2*i+1];
              idx_d[i] = idx_q[2*i+1];
            end else begin
              val_d[i] = val_q[2*i];
              idx_d[i] = idx_q[2*i];
            end
            if (rnd_q == '0) begin
              r1_d[i] = b_wins(val_q[2*i], val_q[2*i+1]);
            end
          end
        end
        rnd_d = rnd_q + LOG2N'(1);
        if (rnd_q == LOG2N'(LOG2N-1)) begin
          state_d     = DONE;
          out_value_d = val_d[0];
          out_index_d = idx_d[0];
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they are registered outputs.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      r1_q        <= '0;
      out_value_q <= '0;
      out_index_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int j = 0; j < N_IN; j++) begin
        val_q[j] <= '0;
        idx_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      r1_q        <= r1_d;
      out_value_q <= out_value_d;
      out_index_q <= out_index_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      for (int j = 0; j < N_IN; j++) begin
        val_q[j] <= val_d[j];
        idx_q[j] <= idx_d[j];
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_value  = out_value_q;
  assign bus.out_index  = out_index_q;
  assign bus.round1_cmp = r1_q;
  assign bus.busy       = busy_q;

endmodule
